// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU; result is {remainder, quotient}.
// Handshake: start_i held until ready_o, divide-by-zero short-circuits to a zero result.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] op1_abs, op2_abs;
    logic [32:0] diff;
    logic [31:0] quotient, remainder;

    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    assign op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    assign diff      = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
    assign quotient  = quo_neg_q ? (~dividend_q[31:0] + 32'd1) : dividend_q[31:0];
    assign remainder = rem_neg_q ? (~dividend_q[64:33] + 32'd1) : dividend_q[64:33];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        result_d   = result_q;
        ready_d    = ready_q;

        unique case (state_q)
            StFree: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = StByZero;
                    end else begin
                        dividend_d = {32'd0, op1_abs, 1'b0};
                        divisor_d  = op2_abs;
                        quo_neg_d  = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        rem_neg_d  = signed_div_i & opdata1_i[31];
                        cnt_d      = 6'd0;
                        state_d    = StOn;
                    end
                end
            end
            StByZero: begin
                if (annul_i || !start_i) begin
                    state_d = StFree;
                end else begin
                    state_d  = StEnd;
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                end
            end
            StOn: begin
                if (annul_i || !start_i) begin
                    state_d = StFree;
                    cnt_d   = 6'd0;
                end else if (cnt_q == 6'd32) begin
                    state_d  = StEnd;
                    result_d = {remainder, quotient};
                    ready_d  = 1'b1;
                end else begin
                    if (diff[32]) begin
                        dividend_d = {dividend_q[63:0], 1'b0};
                    end else begin
                        dividend_d = {diff[31:0], dividend_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StEnd: begin
                // annul_i is deliberately ignored here: the result is already committed.
                if (!start_i) begin
                    state_d  = StFree;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = StFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFree;
            cnt_q      <= 6'd0;
            dividend_q <= 65'd0;
            divisor_q  <= 32'd0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, abort/reset scenarios and a random
// back-to-back sweep against a truncating-division reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = 32'd0;
    logic [31:0] opdata2 = 32'd0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;

    int total = 0;
    int bad   = 0;

    div_unit u_dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    // Truncating division; remainder carries the dividend's sign; x/0 yields 0.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Edges counted include the sampling edge, so normal = 34, by-zero = 2.
    function automatic int model_edges(input logic [31:0] b);
        return (b == 32'd0) ? 2 : 34;
    endfunction

    // Issues one request, returns the result, edges to ready, and {ready,result} after drop.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [63:0] res, output int n, output logic [64:0] post);
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        n          = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (ready) break;
        end
        res   = result;
        start = 1'b0;
        @(posedge clk);
        #1;
        post = {ready, result};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            bad++;
            $display("FAIL reset: ready=%b result=%h required ready=0 result=0", ready, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] a_tab [4] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9};
        logic [31:0] b_tab [4] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd2};
        logic        s_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [63:0] e_tab [4] = '{{32'd2, 32'd14}, {32'hFFFFFFFF, 32'hFFFFFFFD},
                                   {32'd1, 32'hFFFFFFFD}, {32'd1, 32'h7FFFFFFC}};
        logic [63:0] res;
        logic [64:0] post;
        int          n;
        for (int i = 0; i < 4; i++) begin
            run_div(a_tab[i], b_tab[i], s_tab[i], res, n, post);
            total++;
            if (n !== 34) begin
                bad++;
                $display("FAIL directed_latency[%0d]: edges=%0d required=34", i, n);
            end
            total++;
            if (res !== e_tab[i]) begin
                bad++;
                $display("FAIL directed_result[%0d]: got=%h required=%h", i, res, e_tab[i]);
            end
            total++;
            if (post !== 65'd0) begin
                bad++;
                $display("FAIL directed_clear[%0d]: got=%h required=0", i, post);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] res;
        logic [64:0] post;
        int          n;
        for (int s = 0; s < 2; s++) begin
            run_div(32'd1234, 32'd0, s[0], res, n, post);
            total++;
            if (n !== 2 || res !== 64'd0) begin
                bad++;
                $display("FAIL div_zero[s=%0d]: edges=%0d result=%h required edges=2 result=0",
                         s, n, res);
            end
            total++;
            if (post !== 65'd0) begin
                bad++;
                $display("FAIL div_zero_clear[s=%0d]: got=%h required=0", s, post);
            end
        end
    endtask

    task automatic test_annul();
        logic [63:0] res;
        logic [64:0] post;
        int          n;
        int          seen = 0;
        opdata1    = 32'd100;
        opdata2    = 32'd3;
        signed_div = 1'b0;
        start      = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            bad++;
            $display("FAIL busy_outputs: ready=%b result=%h required 0/0", ready, result);
        end
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready !== 1'b0 || result !== 64'd0) seen++;
            @(posedge clk);
            #1;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL annul_no_ready: active_cycles=%0d required=0", seen);
        end
        run_div(32'd50, 32'd5, 1'b0, res, n, post);
        total++;
        if (n !== 34 || res !== {32'd0, 32'd10}) begin
            bad++;
            $display("FAIL after_annul: edges=%0d result=%h required edges=34 result=%h",
                     n, res, {32'd0, 32'd10});
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        logic [64:0] post;
        int          n;
        opdata1    = 32'd999;
        opdata2    = 32'd4;
        signed_div = 1'b0;
        start      = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            bad++;
            $display("FAIL reset_mid: ready=%b result=%h required 0/0", ready, result);
        end
        rst = 1'b0;
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, res, n, post);
        total++;
        if (n !== 34 || res !== {32'd0, 32'h80000000}) begin
            bad++;
            $display("FAIL overflow_after_reset: edges=%0d result=%h required edges=34 result=%h",
                     n, res, {32'd0, 32'h80000000});
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'h7FFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic        sgn;
        logic [63:0] res, exp;
        logic [64:0] post;
        int          n;
        for (int i = 0; i < 60; i++) begin
            a   = pick();
            b   = pick();
            sgn = 1'($urandom_range(0, 1));
            exp = model(a, b, sgn);
            run_div(a, b, sgn, res, n, post);
            total++;
            if (res !== exp || n !== model_edges(b) || post !== 65'd0) begin
                bad++;
                $display("FAIL random[%0d] %h/%h s=%b: result=%h edges=%0d post=%h required result=%h edges=%0d post=0",
                         i, a, b, sgn, res, n, post, exp, model_edges(b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
